// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer for a combinational-read
// instruction memory. It holds one fetched instruction for the decoder,
// supports stall, redirect (branch/jump) and halt.
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_count/stall_count.
//
// state | meaning
// ------+-------------------------------------------------------------
// RST   | one cycle after reset, no fetch, always advances to RUN
// RUN   | fetching whenever the output slot is free
// HALT  | no fetching; exits only through redirect or reset
module fetch_controller #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  input  logic       halt_req,
  output logic       halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic       consume;
  logic       slot_free;
  logic       do_fetch;

  // Handshake and fetch-slot decode from the current registers and inputs.
  always_comb begin
    consume   = instr_valid && instr_ready;
    slot_free = !instr_valid || consume;
    do_fetch  = (state == S_RUN) && !redirect_valid && !halt_req && slot_free;
  end

  assign imem_addr = pc;
  assign halted    = (state == S_HALT) && !instr_valid;

  // Sequencer: state, PC and the held instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RST;
      pc          <= RESET_PC;
      instr       <= 8'h00;
      instr_pc    <= 8'h00;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_RST: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (redirect_valid) begin
            // Redirect flushes the held instruction even if it is consumed now.
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
          end else if (halt_req) begin
            state <= S_HALT;
            if (consume) instr_valid <= 1'b0;
          end else if (do_fetch) begin
            instr       <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 8'd1;
          end
        end
        S_HALT: begin
          if (redirect_valid) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            state       <= S_RUN;
          end else if (consume) begin
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state <= S_RST;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating performance counters for fetches and decoder back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 16'h0000;
      stall_count <= 16'h0000;
    end else begin
      if (do_fetch && (fetch_count != 16'hFFFF))
        fetch_count <= fetch_count + 16'd1;
      if (instr_valid && !instr_ready && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 8'h00: program-counter value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_addr  output  8  address driven to the combinational-read instruction memory; always equal to the PC register.
REQ-005 imem_data  input  8  instruction returned by the memory for imem_addr in the same cycle.
REQ-006 instr  output  8  registered fetched instruction.
REQ-007 instr_pc  output  8  address from which instr was fetched.
REQ-008 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-009 instr_ready  input  1  decoder accepts instr this cycle when instr_valid=1.
REQ-010 redirect_valid  input  1  branch/jump taken; redirect_pc is the new PC.
REQ-011 redirect_pc  input  8  target address.
REQ-012 halt_req  input  1  stop issuing fetches.
REQ-013 halted  output  1  state HALT and no valid instruction held.

Function
REQ-014 States: RST (entered by reset), RUN, HALT; RST always moves to RUN on the next cycle without fetching.
REQ-015 Transfer: an instruction is consumed in a cycle where instr_valid=1 and instr_ready=1.
REQ-016 Fetch slot: in RUN, the slot is free when instr_valid=0 or the held instruction is consumed this cycle.
REQ-017 Fetch: in RUN with a free slot and no redirect, instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1. Latency is 1 cycle from address to instr.
REQ-018 PC arithmetic: 8-bit modulo; 8'hFF+1 wraps to 8'h00 with no flag.
REQ-019 Stall: instr_valid=1 and instr_ready=0 holds instr, instr_pc, instr_valid and pc unchanged.
REQ-020 Consume without refill: a consumed instruction with no new fetch that cycle clears instr_valid.
REQ-021 Redirect: redirect_valid=1 in RUN or HALT sets pc<=redirect_pc and instr_valid<=0, which flushes the held instruction whether or not it was consumed. No fetch occurs that cycle; the state becomes RUN.
REQ-022 Halt: halt_req=1 in RUN without redirect moves the state to HALT. No fetch occurs in that cycle or while in HALT. A held instruction stays until consumed.
REQ-023 Priority: redirect_valid beats halt_req in the same cycle, and halt_req is ignored that cycle.
REQ-024 HALT exits only by redirect or reset; halt_req in HALT has no effect.
REQ-025 halted = (state==HALT) && !instr_valid, combinational from registers.

Reset
REQ-026 rst=1 at a clock edge sets state=RST, pc=RESET_PC, instr=8'h00, instr_pc=8'h00 and instr_valid=0, overriding all other inputs. This includes reset mid-stall and mid-redirect.
REQ-027 After rst falls, the first valid instruction is from RESET_PC, 2 cycles later (RST, then fetch in RUN).

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN: when defined, add outputs fetch_count[15:0] and stall_count[15:0]. Both reset to 0 and saturate at 16'hFFFF. fetch_count increments per REQ-017 fetch. stall_count increments per cycle with instr_valid=1 and instr_ready=0.
REQ-029 Without FETCH_PERF_CNT_EN, those ports and counters do not exist; all other behaviour is identical.

Verification
REQ-030 Straight-line: reset, instr_ready=1 held, memory[0..3]=B0,B5,BA,BF -> instr_valid rises cycle 2; instr sequence B0,B5,BA,BF with instr_pc 0,1,2,3 on consecutive cycles.
REQ-031 Stall: instr_ready=0 for 3 cycles while instr_pc=2 -> instr/instr_pc/imem_addr frozen at (BA,2,3); with the macro, stall_count=3; after release, instr_pc=3 follows next cycle.
REQ-032 Redirect: redirect_valid=1, redirect_pc=8'h14 while instr_pc=5 is held unconsumed -> next cycle instr_valid=0, imem_addr=14; following cycle instr_pc=14.
REQ-033 Wrap and halt: redirect to 8'hFE, then fetch FE, FF, 00. Assert halt_req after 00 is fetched -> no further fetch, halted=1 once 00 is consumed. Redirect_pc=8'h00 then resumes fetching.
REQ-034 Simultaneity and reset: redirect_valid and halt_req both asserted -> state RUN at the redirect target. Asserting rst during a stall -> instr_valid=0, pc=RESET_PC on the next edge.
